// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
//
// EX-stage requester for the multi-cycle iterative divider. Accepts a DIV/DIVU
// from EX, hands the operands to the divider, holds the pipeline stalled until
// the divider's done pulse, then presents quotient/remainder for the HI/LO
// write. A zero divisor bypasses the divider entirely. A pipeline flush kills
// the in-flight divide, and a watchdog aborts a divide that never completes.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req               EX holds a valid DIV/DIVU
//   i_signed            1 = DIV, 0 = DIVU
//   i_op_a, i_op_b      dividend, divisor
//   i_flush             pipeline flush, kills the in-flight divide
//   o_stall             stall request to the pipeline controller
//   o_hilo_we           one-cycle HI/LO write strobe
//   o_hi, o_lo          remainder, quotient
//   o_dbz               divide-by-zero flag, coincident with o_hilo_we
//   o_err               one-cycle watchdog abort pulse
//   o_div_start         start request to the divider
//   o_div_signed        signed mode to the divider
//   o_div_op0/op1       dividend/divisor to the divider
//   o_div_cancel        cancel to the divider
//   i_div_ready         divider idle; start accepted on start && ready
//   i_div_done          one-cycle result-valid pulse
//   i_div_result        {remainder, quotient}, valid while i_div_done
// -----------------------------------------------------------------------------
module div_issue_ctrl #(
    parameter int N_REG   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req,
    input  logic                 i_signed,
    input  logic [N_REG-1:0]     i_op_a,
    input  logic [N_REG-1:0]     i_op_b,
    input  logic                 i_flush,
    output logic                 o_stall,
    output logic                 o_hilo_we,
    output logic [N_REG-1:0]     o_hi,
    output logic [N_REG-1:0]     o_lo,
    output logic                 o_dbz,
    output logic                 o_err,
    output logic                 o_div_start,
    output logic                 o_div_signed,
    output logic [N_REG-1:0]     o_div_op0,
    output logic [N_REG-1:0]     o_div_op1,
    output logic                 o_div_cancel,
    input  logic                 i_div_ready,
    input  logic                 i_div_done,
    input  logic [2*N_REG-1:0]   i_div_result
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [N_REG-1:0]   r_op_a;
    logic [N_REG-1:0]   r_op_b;
    logic               r_signed;
    logic [N_REG-1:0]   r_hi;
    logic [N_REG-1:0]   r_lo;
    logic               r_dbz;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_div0;
    logic               w_timeout;
    logic               w_active;

    assign w_accept  = i_req && !i_flush;
    assign w_div0    = (i_op_b == '0);
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));
    // Outputs are forced low for the whole reset cycle, regardless of the
    // state register's value before the first reset edge.
    assign w_active  = !i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_signed <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_dbz    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_div0) begin
                            // Zero divisor: result is defined as 0/0, the
                            // divider is never started.
                            r_hi    <= '0;
                            r_lo    <= '0;
                            r_dbz   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_op_a   <= i_op_a;
                            r_op_b   <= i_op_b;
                            r_signed <= i_signed;
                            r_state  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                    end else if (i_div_ready) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Flush beats a coincident done; done beats the watchdog.
                    if (i_flush) begin
                        r_state <= S_IDLE;
                    end else if (i_div_done) begin
                        r_hi    <= i_div_result[2*N_REG-1:N_REG];
                        r_lo    <= i_div_result[N_REG-1:0];
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_dbz   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stall is released in DONE so the instruction retires on that edge.
    assign o_stall      = w_active && (((r_state == S_IDLE) && w_accept) ||
                                       (r_state == S_ISSUE) ||
                                       (r_state == S_WAIT));
    assign o_div_start  = w_active && (r_state == S_ISSUE);
    assign o_div_signed = w_active && r_signed;
    assign o_div_op0    = w_active ? r_op_a : '0;
    assign o_div_op1    = w_active ? r_op_b : '0;
    assign o_err        = w_active && (r_state == S_WAIT) && !i_flush &&
                          !i_div_done && w_timeout;
    assign o_div_cancel = w_active && ((((r_state == S_ISSUE) || (r_state == S_WAIT)) && i_flush) ||
                                       o_err);
    assign o_hilo_we    = w_active && (r_state == S_DONE) && !i_flush;
    assign o_dbz        = o_hilo_we && r_dbz;
    assign o_hi         = w_active ? r_hi : '0;
    assign o_lo         = w_active ? r_lo : '0;

endmodule
